// File: rtl/sdp_block_ram_pkg.sv
// Shared types and helpers for the simple dual-port block RAM.
// The optional power-up clear is enabled with `define SDP_BLOCK_RAM_CLEAR_EN.
package sdp_block_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/sdp_block_ram_core.sv
// Storage array with per-lane write enables and a registered, read-first read port.
module sdp_block_ram_core
  import sdp_block_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned LANE_WIDTH    = 8,
  parameter string       RAM_STYLE     = "block"
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_en,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0]   wr_be,
  input  logic [ADDRESS_WIDTH-1:0]                        wr_addr,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
  input  logic                                            rd_en,
  input  logic [ADDRESS_WIDTH-1:0]                        rd_addr,
  output logic [DATA_WIDTH-1:0]                           rd_data
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane_width
    $error("sdp_block_ram_core: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (RAM_STYLE != "block" && RAM_STYLE != "distributed") begin : g_bad_ram_style
    $error("sdp_block_ram_core: RAM_STYLE must be \"block\" or \"distributed\"");
  end

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM primitives; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // NOTE: non-blocking updates mean a same-edge write is not yet visible here, giving read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sdp_block_ram.sv
// Simple dual-port RAM: ready/clear control, read-valid tracking and optional output register.
// Defining SDP_BLOCK_RAM_CLEAR_EN zero-fills the array after every reset before ready rises.
module sdp_block_ram
  import sdp_block_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned LANE_WIDTH    = 8,
  parameter int unsigned OUT_REG       = 0,
  parameter string       RAM_STYLE     = "block"
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            wr_en,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0]   wr_be,
  input  logic [ADDRESS_WIDTH-1:0]                        wr_addr,
  input  logic [DATA_WIDTH-1:0]                           wr_data,
  input  logic                                            rd_en,
  input  logic [ADDRESS_WIDTH-1:0]                        rd_addr,
  output logic [DATA_WIDTH-1:0]                           rd_data,
  output logic                                            rd_valid,
  output logic                                            ready
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH, LANE_WIDTH);

  logic                     rd_fire;
  logic                     wr_fire;
  logic                     core_wr_en;
  logic [LANES-1:0]         core_wr_be;
  logic [ADDRESS_WIDTH-1:0] core_wr_addr;
  logic [DATA_WIDTH-1:0]    core_wr_data;
  logic [DATA_WIDTH-1:0]    core_rd_data;
  logic                     core_valid;

  assign rd_fire = ready & rd_en;
  assign wr_fire = ready & wr_en;

`ifdef SDP_BLOCK_RAM_CLEAR_EN
  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clr_addr;
  logic                     clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDRESS_WIDTH'(1);
          if (clr_addr == '1) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: ready <= 1'b1;
      endcase
    end
  end

  // The clear port write is held off while reset is asserted so the array is untouched then.
  assign clearing     = rst_n & (state == ST_CLEAR);
  assign core_wr_en   = clearing | wr_fire;
  assign core_wr_be   = clearing ? '1 : wr_be;
  assign core_wr_addr = clearing ? clr_addr : wr_addr;
  assign core_wr_data = clearing ? '0 : wr_data;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  assign core_wr_en   = wr_fire;
  assign core_wr_be   = wr_be;
  assign core_wr_addr = wr_addr;
  assign core_wr_data = wr_data;
`endif

  sdp_block_ram_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .LANE_WIDTH    (LANE_WIDTH),
    .RAM_STYLE     (RAM_STYLE)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (core_wr_en),
    .wr_be   (core_wr_be),
    .wr_addr (core_wr_addr),
    .wr_data (core_wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (core_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_valid <= 1'b0;
    end else begin
      core_valid <= rd_fire;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= core_valid;
        if (core_valid) data_q <= core_rd_data;
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end else begin : g_no_out_reg
    assign rd_data  = core_rd_data;
    assign rd_valid = core_valid;
  end

endmodule
